// File: rtl/key_exp_pkg.sv
// Shared types and helpers for the iterative AES key-schedule engine:
// key-size enum, Nk/Nr lookup, GF(2^8) xtime and the AES S-box.
package key_exp_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'd0,
        MODE_192  = 2'd1,
        MODE_256  = 2'd2,
        MODE_RSVD = 2'd3
    } key_mode_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [3:0] nk_of(input key_mode_e m);
        case (m)
            MODE_128: return 4'd4;
            MODE_192: return 4'd6;
            default:  return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input key_mode_e m);
        case (m)
            MODE_128: return 4'd10;
            MODE_192: return 4'd12;
            default:  return 4'd14;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES S-box lookups on a 32-bit word (SubWord), purely combinational.
module aes_sbox_word
    import key_exp_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);

    // byte-wise substitution
    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            dout[8*i +: 8] = sbox(din[8*i +: 8]);
        end
    end

endmodule

// File: rtl/key_expand_iter.sv
// Iterative AES-128/192/256 key-schedule engine. Produces one schedule word
// per cycle from a sliding window of the last Nk words, packs four words into
// a round key and streams round keys out over a valid/ready handshake.
// Optional build macro: KEY_EXPAND_ZEROIZE_EN (clear key material after done/abort).
module key_expand_iter
    import key_exp_pkg::*;
#(
    parameter int unsigned MAX_NK = 8,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [255:0]      key_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              rk_valid_o,
    input  logic              rk_ready_i,
    output logic [127:0]      rk_o,
    output logic [RIDX_W-1:0] rk_idx_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    key_mode_e         mode_q;
    logic [255:0]      key_q;
    logic [31:0]       win_q [MAX_NK];
    logic [5:0]        j_q;
    logic [3:0]        kpos_q;
    logic [7:0]        rcon_q;
    logic [1:0]        asm_cnt_q;
    logic [31:0]       asm_q [3];
    logic [127:0]      rk_q;
    logic              rk_valid_q;
    logic [RIDX_W-1:0] rk_idx_q;
    logic [RIDX_W-1:0] rnd_q;
    logic              err_q;

    logic [3:0]  nk;
    logic [5:0]  total_words;
    logic        start_ok;
    logic        hs;
    logic        stall;
    logic        advance;
    logic        load;
    logic        last_word;
    logic        final_hs;
    logic [31:0] key_w [8];
    logic [31:0] w_nk;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] new_word;

    assign nk          = nk_of(mode_q);
    assign total_words = {nr_of(mode_q) + 4'd1, 2'b00};
    assign start_ok    = (state_q == ST_IDLE) && start_i && (mode_i != MODE_RSVD) && !abort_i;
    assign hs          = rk_valid_q && rk_ready_i;
    assign stall       = rk_valid_q && !rk_ready_i && (asm_cnt_q == 2'd3);
    assign advance     = (state_q == ST_GEN) && !stall && !abort_i;
    assign load        = advance && (asm_cnt_q == 2'd3);
    assign last_word   = (j_q == total_words - 6'd1);
    assign final_hs    = (state_q == ST_FLUSH) && hs && !abort_i;

    // One S-box bank serves both SubWord paths; RotWord only on the j mod Nk == 0 step
    assign sub_in = (kpos_q == 4'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

    aes_sbox_word u_sbox (
        .din  (sub_in),
        .dout (sub_out)
    );

    // next schedule word from the window (win_q[k] holds w[j-1-k])
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            key_w[i] = key_q[255 - 32*i -: 32];
        end
        case (mode_q)
            MODE_128: w_nk = win_q[3];
            MODE_192: w_nk = win_q[5];
            default:  w_nk = win_q[7];
        endcase
        if (j_q < {2'b00, nk}) begin
            new_word = key_w[j_q[2:0]];
        end else if (kpos_q == 4'd0) begin
            new_word = w_nk ^ sub_out ^ {rcon_q, 24'h0};
        end else if ((mode_q == MODE_256) && (kpos_q == 4'd4)) begin
            new_word = w_nk ^ sub_out;
        end else begin
            new_word = w_nk ^ win_q[0];
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; abort wins over everything
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_ok) state_d = ST_GEN;
                ST_GEN:   if (advance && last_word) state_d = ST_FLUSH;
                ST_FLUSH: if (hs) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // datapath: key latch, window, counters, assembler and output register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_q     <= MODE_128;
            key_q      <= '0;
            j_q        <= '0;
            kpos_q     <= '0;
            rcon_q     <= 8'h01;
            asm_cnt_q  <= '0;
            rk_q       <= '0;
            rk_valid_q <= 1'b0;
            rk_idx_q   <= '0;
            rnd_q      <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < MAX_NK; i++) win_q[i] <= '0;
            for (int unsigned i = 0; i < 3; i++) asm_q[i] <= '0;
        end else begin
            err_q <= (state_q == ST_IDLE) && start_i && (mode_i == MODE_RSVD) && !abort_i;
            if (start_ok) begin
                mode_q    <= key_mode_e'(mode_i);
                key_q     <= key_i;
                j_q       <= '0;
                kpos_q    <= '0;
                rcon_q    <= 8'h01;
                asm_cnt_q <= '0;
                rnd_q     <= '0;
            end else if (advance) begin
                for (int unsigned i = MAX_NK - 1; i > 0; i--) win_q[i] <= win_q[i-1];
                win_q[0] <= new_word;
                j_q      <= j_q + 6'd1;
                kpos_q   <= (kpos_q == nk - 4'd1) ? 4'd0 : kpos_q + 4'd1;
                if ((j_q >= {2'b00, nk}) && (kpos_q == 4'd0)) begin
                    rcon_q <= xtime(rcon_q);
                end
                if (asm_cnt_q == 2'd3) begin
                    rk_q      <= {asm_q[0], asm_q[1], asm_q[2], new_word};
                    rk_idx_q  <= rnd_q;
                    rnd_q     <= rnd_q + 1'b1;
                    asm_cnt_q <= 2'd0;
                end else begin
                    asm_q[asm_cnt_q] <= new_word;
                    asm_cnt_q        <= asm_cnt_q + 2'd1;
                end
            end

            // a load in the same cycle as a handshake keeps valid high
            if (abort_i) begin
                rk_valid_q <= 1'b0;
            end else if (load) begin
                rk_valid_q <= 1'b1;
            end else if (hs) begin
                rk_valid_q <= 1'b0;
            end

`ifdef KEY_EXPAND_ZEROIZE_EN
            // wipe key material once the run ends or is abandoned
            if (abort_i || final_hs) begin
                key_q <= '0;
                rk_q  <= '0;
                for (int unsigned i = 0; i < MAX_NK; i++) win_q[i] <= '0;
                for (int unsigned i = 0; i < 3; i++) asm_q[i] <= '0;
            end
`endif
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign err_o      = err_q;
    assign rk_valid_o = rk_valid_q;
    assign rk_idx_o   = rk_idx_q;
    assign done_o     = final_hs;
`ifdef KEY_EXPAND_ZEROIZE_EN
    assign rk_o       = rk_valid_q ? rk_q : '0;
`else
    assign rk_o       = rk_q;
`endif

endmodule
